// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks E-stage producers through shadow M/W slots and derives
// the D-stage stall, D/E forward selects and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TNEW_W = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  D_rs,
    input  logic [REG_W-1:0]  D_rt,
    input  logic [TNEW_W-1:0] D_Tuse_rs,
    input  logic [TNEW_W-1:0] D_Tuse_rt,
    input  logic [REG_W-1:0]  E_rs,
    input  logic [REG_W-1:0]  E_rt,
    input  logic [REG_W-1:0]  E_Wreg,
    input  logic [TNEW_W-1:0] E_T_new,
    input  logic              E_GRF_WE,
    output logic              stall,
    output logic [1:0]        D_fwd_rs,
    output logic [1:0]        D_fwd_rt,
    output logic [1:0]        E_fwd_rs,
    output logic [1:0]        E_fwd_rt,
    output logic [REG_W-1:0]  M_Wreg,
    output logic [REG_W-1:0]  W_Wreg,
    output logic [TNEW_W-1:0] M_T_new,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_E    = 2'd1;
    localparam logic [1:0] SEL_M    = 2'd2;
    localparam logic [1:0] SEL_W    = 2'd3;

    logic m_we;
    logic w_we;

    // A slot matches a source only if it writes and the register is not $0.
    function automatic logic hit(input logic we, input logic [REG_W-1:0] wreg,
                                 input logic [REG_W-1:0] r);
        return we && (r != '0) && (wreg == r);
    endfunction

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    // Youngest matching slot wins; a not-yet-ready winner blocks older slots.
    function automatic logic [1:0] d_sel(input logic [REG_W-1:0] r);
        if (hit(E_GRF_WE, E_Wreg, r))
            return (E_T_new == '0) ? SEL_E : SEL_NONE;
        else if (hit(m_we, M_Wreg, r))
            return (M_T_new == '0) ? SEL_M : SEL_NONE;
        else if (hit(w_we, W_Wreg, r))
            return SEL_W;
        return SEL_NONE;
    endfunction

    function automatic logic [1:0] e_sel(input logic [REG_W-1:0] r);
        if (hit(m_we, M_Wreg, r))
            return (M_T_new == '0) ? SEL_M : SEL_NONE;
        else if (hit(w_we, W_Wreg, r))
            return SEL_W;
        return SEL_NONE;
    endfunction

    function automatic logic src_stall(input logic [REG_W-1:0] r, input logic [TNEW_W-1:0] tuse);
        if (tuse == '1)
            return 1'b0;
        return (hit(E_GRF_WE, E_Wreg, r) && (E_T_new > tuse)) ||
               (hit(m_we, M_Wreg, r) && (M_T_new > tuse));
    endfunction

    always_comb begin
        stall    = src_stall(D_rs, D_Tuse_rs) || src_stall(D_rt, D_Tuse_rt);
        D_fwd_rs = d_sel(D_rs);
        D_fwd_rt = d_sel(D_rt);
        E_fwd_rs = e_sel(E_rs);
        E_fwd_rt = e_sel(E_rt);
    end

    // Shadow slots; W latency is always zero so only its destination is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            M_Wreg  <= '0;
            m_we    <= 1'b0;
            M_T_new <= '0;
            W_Wreg  <= '0;
            w_we    <= 1'b0;
        end else begin
            M_Wreg  <= E_Wreg;
            m_we    <= E_GRF_WE;
            M_T_new <= sat_dec(E_T_new);
            W_Wreg  <= M_Wreg;
            w_we    <= m_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: expectations queued at drive time, popped and compared
// after outputs settle; a 4-bit-counter instance exercises saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_rs, E_rt, E_Wreg;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, E_T_new;
    logic       E_GRF_WE;

    logic        a_stall, b_stall;
    logic [1:0]  a_dfrs, a_dfrt, a_efrs, a_efrt, b_dfrs, b_dfrt, b_efrs, b_efrt;
    logic [4:0]  a_mw, a_ww, b_mw, b_ww;
    logic [1:0]  a_mt, b_mt;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    typedef struct {
        logic        stall;
        logic [1:0]  dfrs, dfrt, efrs, efrt;
        logic [4:0]  mw, ww;
        logic [1:0]  mt;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference state for the registered outputs.
    logic [4:0]  mdl_mw, mdl_ww;
    logic [1:0]  mdl_mt;
    logic [31:0] mdl_cnt;
    logic [3:0]  mdl_cnt4;
    logic        cur_stall;

    hazard_scoreboard #(.REG_W(5), .TNEW_W(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .E_rs(E_rs), .E_rt(E_rt),
        .E_Wreg(E_Wreg), .E_T_new(E_T_new), .E_GRF_WE(E_GRF_WE),
        .stall(a_stall), .D_fwd_rs(a_dfrs), .D_fwd_rt(a_dfrt),
        .E_fwd_rs(a_efrs), .E_fwd_rt(a_efrt), .M_Wreg(a_mw), .W_Wreg(a_ww),
        .M_T_new(a_mt), .stall_count(a_cnt)
    );

    hazard_scoreboard #(.REG_W(5), .TNEW_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .E_rs(E_rs), .E_rt(E_rt),
        .E_Wreg(E_Wreg), .E_T_new(E_T_new), .E_GRF_WE(E_GRF_WE),
        .stall(b_stall), .D_fwd_rs(b_dfrs), .D_fwd_rt(b_dfrt),
        .E_fwd_rs(b_efrs), .E_fwd_rt(b_efrt), .M_Wreg(b_mw), .W_Wreg(b_ww),
        .M_T_new(b_mt), .stall_count(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] drs, input logic [4:0] drt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] ers, input logic [4:0] ert,
                         input logic [4:0] ewreg, input logic [1:0] etnew, input logic ewe);
        D_rs = drs; D_rt = drt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
        E_rs = ers; E_rt = ert; E_Wreg = ewreg; E_T_new = etnew; E_GRF_WE = ewe;
    endtask

    // Queue the expected combinational results plus the modelled registered state.
    task automatic expect_out(input logic st, input logic [1:0] dfrs, input logic [1:0] dfrt,
                              input logic [1:0] efrs, input logic [1:0] efrt);
        exp_t e;
        e.stall = st; e.dfrs = dfrs; e.dfrt = dfrt; e.efrs = efrs; e.efrt = efrt;
        e.mw = mdl_mw; e.ww = mdl_ww; e.mt = mdl_mt; e.cnt = mdl_cnt; e.cnt4 = mdl_cnt4;
        exp_q.push_back(e);
        cur_stall = st;
    endtask

    task automatic sample(input string tag);
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".stall"}, 32'(a_stall), 32'(e.stall));
        chk({tag, ".dfrs"},  32'(a_dfrs),  32'(e.dfrs));
        chk({tag, ".dfrt"},  32'(a_dfrt),  32'(e.dfrt));
        chk({tag, ".efrs"},  32'(a_efrs),  32'(e.efrs));
        chk({tag, ".efrt"},  32'(a_efrt),  32'(e.efrt));
        chk({tag, ".mw"},    32'(a_mw),    32'(e.mw));
        chk({tag, ".ww"},    32'(a_ww),    32'(e.ww));
        chk({tag, ".mt"},    32'(a_mt),    32'(e.mt));
        chk({tag, ".cnt"},   a_cnt,        e.cnt);
        chk({tag, ".b_stall"}, 32'(b_stall), 32'(e.stall));
        chk({tag, ".b_fwd"}, 32'({b_dfrs, b_dfrt, b_efrs, b_efrt}),
                             32'({e.dfrs, e.dfrt, e.efrs, e.efrt}));
        chk({tag, ".b_slot"}, 32'({b_mw, b_ww, b_mt}), 32'({e.mw, e.ww, e.mt}));
        chk({tag, ".b_cnt"}, 32'(b_cnt), 32'(e.cnt4));
    endtask

    task automatic exp_chk(input string tag, input logic st, input logic [1:0] dfrs,
                           input logic [1:0] dfrt, input logic [1:0] efrs, input logic [1:0] efrt);
        expect_out(st, dfrs, dfrt, efrs, efrt);
        sample(tag);
    endtask

    task automatic model_clear();
        mdl_mw = '0; mdl_ww = '0; mdl_mt = '0; mdl_cnt = '0; mdl_cnt4 = '0; cur_stall = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (cur_stall) begin
            mdl_cnt  = mdl_cnt + 32'd1;
            mdl_cnt4 = (mdl_cnt4 == 4'hf) ? 4'hf : mdl_cnt4 + 4'd1;
        end
        mdl_ww = mdl_mw;
        mdl_mw = E_GRF_WE || E_Wreg != '0 ? E_Wreg : E_Wreg;
        mdl_mt = (E_T_new == 2'd0) ? 2'd0 : E_T_new - 2'd1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        model_clear();
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        #2;
        exp_chk("reset", 0, 0, 0, 0, 0);
        #5 reset = 1'b1;

        // lw $1 in E, D reads $1 at Tuse 1
        drive(1, 0, 1, 3, 0, 0, 1, 2, 1);
        exp_chk("lw_e", 1, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
        exp_chk("lw_m", 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 3, 3, 1, 0, 0, 0, 0);
        exp_chk("lw_w", 0, 0, 0, 3, 0);
        step();

        // jal then jr $31
        drive(31, 0, 0, 3, 0, 0, 31, 0, 1);
        exp_chk("jal", 0, 1, 0, 0, 0);
        step();

        // ori $2 then beq $2; rt reads $31 now sitting in W
        drive(2, 0, 0, 3, 0, 0, 2, 1, 1);
        exp_chk("ori_e", 1, 0, 0, 0, 0);
        step();
        drive(2, 31, 0, 3, 0, 0, 0, 0, 0);
        exp_chk("ori_m", 0, 2, 3, 0, 0);
        step();

        // $0 never matches
        drive(0, 0, 0, 0, 0, 0, 0, 2, 1);
        exp_chk("zero", 0, 0, 0, 0, 0);
        step();

        // E and M both write $5: E decides, rs==rt gives identical selects
        drive(5, 5, 3, 3, 0, 0, 5, 2, 1);
        exp_chk("em5_a", 0, 0, 0, 0, 0);
        step();
        drive(5, 5, 3, 3, 5, 0, 5, 0, 1);
        exp_chk("em5_b", 0, 1, 1, 0, 0);
        step();
        drive(5, 0, 3, 3, 5, 0, 5, 1, 1);
        exp_chk("em5_c", 0, 0, 0, 2, 0);
        drive(5, 0, 0, 3, 5, 5, 5, 1, 1);
        exp_chk("em5_d", 1, 0, 0, 2, 2);
        step();

        // Fresh counter, hold the lw stall three cycles
        reset = 1'b0;
        model_clear();
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 3, 0, 0, 1, 2, 1);
            exp_chk($sformatf("hold%0d", i), 1, 0, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0);
        exp_chk("m_only", 1, 0, 0, 0, 0);
        reset = 1'b0;
        model_clear();
        exp_chk("mid_reset", 0, 0, 0, 0, 0);
        #2 reset = 1'b1;

        // Long stall: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            drive(3, 0, 0, 3, 0, 0, 3, 2, 1);
            exp_chk($sformatf("sat%0d", i), 1, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
        exp_chk("sat_end", 0, 0, 0, 0, 0);
        chk("sat_cnt4", 32'(b_cnt), 32'd15);
        chk("sat_cnt32", a_cnt, 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
